// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types, constants and helpers for the push-button
//                conditioner. Defaults assume the 27 MHz board clock.
//  Revision    : 1.0  initial release
// ============================================================================
package btn_pkg;

    // Debounce FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEB_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_DEB_UP = 2'd3
    } btn_state_e;

    // Default cycle counts at 27 MHz: 10 ms, 1 s, 250 ms
    localparam int unsigned c_DEBOUNCE_CYCLES_27M = 270_000;
    localparam int unsigned c_LONG_CYCLES_27M     = 27_000_000;
    localparam int unsigned c_REPEAT_CYCLES_27M   = 6_750_000;

    // Width of a counter that must reach n-1; never narrower than one bit
    function automatic int cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser for a single asynchronous input.
//                Both flops reset to RESET_VAL so the idle level of the pin
//                is presented immediately after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : btn_conditioner
//  Description : Synchronises and debounces a push-button pin and produces a
//                debounced level plus one-cycle press, release and long-press
//                strobes. Defining BTN_REPEAT_EN adds an auto-repeat strobe
//                after a long press; otherwise repeat_pulse is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_27M,
    parameter int unsigned LONG_CYCLES     = c_LONG_CYCLES_27M,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned REPEAT_CYCLES   = c_REPEAT_CYCLES_27M
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int c_DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int c_HOLD_W = cnt_width(LONG_CYCLES);
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);

    // Reject parameter sets the counters cannot honour
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("btn_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("btn_conditioner: REPEAT_CYCLES must be at least 1");
    end

    logic                w_raw_sync;
    logic                w_s;
    btn_state_e          r_state;
    btn_state_e          w_state_nxt;
    logic [c_DEB_W-1:0]  r_deb_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_long_done;
    logic                w_deb_last;
    logic                w_hold_last;
    logic                w_level_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_long_nxt;
    logic                w_repeat_nxt;
    logic                r_level;
    logic                r_press;
    logic                r_release;
    logic                r_long;
    logic                r_repeat;

    // Synchronisers idle at the released pin level so reset never looks like a press
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .i_d (btn_raw),
        .o_q (w_raw_sync)
    );

    // Normalise so that 1 always means pressed
    assign w_s         = ACTIVE_LOW ? ~w_raw_sync : w_raw_sync;
    assign w_deb_last  = (r_deb_cnt == c_DEB_LAST);
    assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a level must stay stable for the full debounce window
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_s) w_state_nxt = ST_DEB_DN;
            end
            ST_DEB_DN: begin
                if (!w_s)           w_state_nxt = ST_IDLE;
                else if (w_deb_last) w_state_nxt = ST_DOWN;
            end
            ST_DOWN: begin
                if (!w_s) w_state_nxt = ST_DEB_UP;
            end
            ST_DEB_UP: begin
                if (w_s)             w_state_nxt = ST_DOWN;
                else if (w_deb_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered level and strobes
    always_comb begin
        w_level_nxt   = (w_state_nxt == ST_DOWN) || (w_state_nxt == ST_DEB_UP);
        w_press_nxt   = (r_state == ST_DEB_DN) && w_s && w_deb_last;
        w_release_nxt = (r_state == ST_DEB_UP) && !w_s && w_deb_last;
        // Long strobe depends only on the hold count, so a release seen on
        // the very same cycle does not suppress it
        w_long_nxt    = (r_state == ST_DOWN) && !r_long_done && w_hold_last;
    end

    // Debounce counter restarts on every state change and saturates at the last count
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_deb_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_deb_cnt <= '0;
        end else if (((r_state == ST_DEB_DN) || (r_state == ST_DEB_UP)) && !w_deb_last) begin
            r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
        end
    end

    // Hold counter: restarts on an accepted press, frozen outside DOWN, stops at the long count
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
        end else if ((r_state == ST_DEB_DN) && (w_state_nxt == ST_DOWN)) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
        end else if ((r_state == ST_DOWN) && !r_long_done) begin
            if (w_hold_last) begin
                r_long_done <= 1'b1;
            end else begin
                r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int c_REP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               w_rep_last;

    assign w_rep_last   = (r_rep_cnt == c_REP_LAST);
    assign w_repeat_nxt = (r_state == ST_DOWN) && r_long_done && w_rep_last;

    // Repeat period counter: runs in DOWN after the long press, frozen in DEB_UP, cleared in IDLE
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rep_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_rep_cnt <= '0;
        end else if ((r_state == ST_DOWN) && r_long_done) begin
            r_rep_cnt <= w_rep_last ? '0 : r_rep_cnt + c_REP_W'(1);
        end
    end
`else
    assign w_repeat_nxt = 1'b0;
`endif

    // Register every output so downstream logic sees glitch-free strobes
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Front-end conditioner for the start/stop push-button and other push-buttons on the 27 MHz board.
- Synchronises the raw pin and debounces it with a saturating counter FSM.
- Emits single-cycle press, release and long-press strobes.
- Sits directly upstream of the stopwatch core, which consumes press_pulse as its start/stop toggle and long_pulse as a clear request.

Parameters:
- DEBOUNCE_CYCLES, 270000, cycles an input level must stay stable before it is accepted (10 ms at 27 MHz); legal range 2 or more.
- LONG_CYCLES, 27000000, cycles of accepted press before long_pulse fires (1 s); must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board buttons); 0 = pin reads 1 when pressed.
- REPEAT_CYCLES, 6750000, auto-repeat period after a long press (250 ms); used only with the optional feature.

Ports:
- sys_clk  input  1  system clock, 27 MHz
- sys_rst  input  1  synchronous reset, active-high
- btn_raw  input  1  asynchronous button pin
- btn_level  output  1  debounced level, 1 = pressed
- press_pulse  output  1  one-cycle strobe on accepted press
- release_pulse  output  1  one-cycle strobe on accepted release
- long_pulse  output  1  one-cycle strobe when a press reaches LONG_CYCLES
- repeat_pulse  output  1  auto-repeat strobe; tied 0 when the optional feature is compiled out

Behaviour:
- Reset and clocking:
  - One clock: sys_clk. Reset is synchronous and active-high: sys_rst sampled on the sys_clk rising edge.
  - Reset clears the FSM to IDLE, both counters to 0, long_done to 0, and all outputs to 0.
  - Both synchroniser flops reset to the released level, so no press is seen just after reset.
- Input path:
  - btn_raw passes through a 2-flop synchroniser.
  - It is then normalised to s (1 = pressed) using ACTIVE_LOW.
- Counters:
  - deb_cnt: width clog2(DEBOUNCE_CYCLES).
  - hold_cnt: width clog2(LONG_CYCLES).
  - Both saturate and never wrap.
- FSM states: IDLE, DEB_DN, DOWN, DEB_UP.
- IDLE:
  - If s=1, go to DEB_DN with deb_cnt=0.
  - btn_level=0.
- DEB_DN:
  - If s=0, return to IDLE (glitch rejected; no pulse).
  - Otherwise deb_cnt increments.
  - On the cycle deb_cnt==DEBOUNCE_CYCLES-1 with s=1, go to DOWN: btn_level<=1, press_pulse<=1 for one cycle, hold_cnt<=0, long_done<=0.
- DOWN:
  - hold_cnt increments while long_done=0.
  - When hold_cnt==LONG_CYCLES-1: long_pulse<=1 for one cycle, long_done<=1, hold_cnt stops.
  - If s=0, go to DEB_UP with deb_cnt=0.
- DEB_UP:
  - If s=1, return to DOWN with no pulse. hold_cnt is frozen during DEB_UP and resumes from its frozen value.
  - On the cycle deb_cnt==DEBOUNCE_CYCLES-1 with s=0, go to IDLE: btn_level<=0, release_pulse<=1 for one cycle.
  - btn_level stays 1 throughout DEB_UP.
- Latency (all outputs registered):
  - Press: clean btn_raw edge to press_pulse is 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
  - Release: same latency for release_pulse.
- Pulse rules:
  - press_pulse and release_pulse never assert in the same cycle.
  - long_pulse fires at most once per accepted press.
  - long_pulse can coincide with the first DEB_UP cycle only if the release is seen on the exact long cycle; long_pulse still fires.
- Reset mid-operation: all state is abandoned with no strobes. A button still held after reset must re-debounce through DEB_DN before press_pulse fires.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - After long_done=1 in DOWN, a rep_cnt counts REPEAT_CYCLES.
  - Each expiry raises repeat_pulse for one cycle and reloads rep_cnt.
  - The first repeat comes REPEAT_CYCLES after long_pulse.
  - rep_cnt is frozen in DEB_UP and cleared on leaving DOWN via IDLE.
- Undefined: no rep_cnt logic; repeat_pulse tied to 0.

Decomposition:
- Package btn_pkg:
  - State enum (IDLE, DEB_DN, DOWN, DEB_UP) with 2-bit encoding.
  - Constant function for counter-width calculation.
  - Default cycle constants for 27 MHz (10 ms, 1 s, 250 ms).
- One sub-module, sync_2ff:
  - Parameter RESET_VAL.
  - Synchronous active-high reset.
  - Reusable for other board inputs.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1):
- Clean press: btn_raw 1->0 held 30 cycles. Require press_pulse exactly once, 7 cycles after the edge; btn_level=1 from that cycle on; long_pulse once, 20 cycles after press_pulse.
- Bounce rejection: btn_raw low for 3 cycles, high 2, low 2, high. Require no pulses and btn_level=0 throughout.
- Release bounce while held: after press, btn_raw high 2 cycles then low again. Require no release_pulse and btn_level stays 1; after release held for 10 cycles, release_pulse exactly once, 7 cycles after the final edge.
- Short press: press held 10 cycles, then released. Require press_pulse and release_pulse once each and no long_pulse.
- Reset mid-press: sys_rst=1 for 1 cycle during DOWN with the button still held. Require all outputs 0 the next cycle, then a fresh press_pulse 7 cycles after reset deasserts.
- BTN_REPEAT_EN: hold 50 cycles after press_pulse. Require long_pulse at +20, then repeat_pulse at +28, +36, +44; without the macro, repeat_pulse stays 0.
